// File: rtl/mhpm_csr_pkg.sv
// rtl/mhpm_csr_pkg.sv - shared CSR addresses and write-value helper for the counter/perf-monitor bank
package mhpm_csr_pkg;

  localparam logic [11:0] MCYCLE_ADDR        = 12'hB00;
  localparam logic [11:0] MINSTRET_ADDR      = 12'hB02;
  localparam logic [11:0] MHPMCOUNTER3_ADDR  = 12'hB03;
  localparam logic [11:0] MCYCLEH_ADDR       = 12'hB80;
  localparam logic [11:0] MCOUNTINHIBIT_ADDR = 12'h320;
  localparam logic [11:0] MHPMEVENT3_ADDR    = 12'h323;
  localparam logic [11:0] HPM_HIGH_OFFSET    = 12'h080;

  // CSRRW / CSRRS / CSRRC result from the current register value
  function automatic logic [31:0] csr_wr_value(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic        set,
                                               input logic        clr);
    if (set)
      return old_val | wdata;
    else if (clr)
      return old_val & ~wdata;
    else
      return wdata;
  endfunction

endpackage

// File: rtl/mhpm_csr_hpm_counter.sv
// rtl/mhpm_csr_hpm_counter.sv - one CNT_WIDTH-bit counter with split low/high CSR write ports
module hpm_counter #(
  parameter int CNT_WIDTH = 64
) (
  input  logic                 cpu_clk,
  input  logic                 cpu_rstn,
  input  logic                 inc,
  input  logic                 wr_lo,
  input  logic                 wr_hi,
  input  logic [31:0]          wr_value,
  output logic [CNT_WIDTH-1:0] value,
  output logic                 wrap
);

  // A wrap only counts when the increment actually lands (no CSR write this cycle)
  assign wrap = inc & ~wr_lo & ~wr_hi & (&value);

  // CSR writes replace one half exactly and suppress the increment; otherwise count
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn)
      value <= '0;
    else if (wr_lo)
      value[31:0] <= wr_value;
    else if (wr_hi)
      value[CNT_WIDTH-1:32] <= wr_value[CNT_WIDTH-33:0];
    else if (inc)
      value <= value + CNT_WIDTH'(1);
  end

endmodule

// File: rtl/mhpm_csr.sv
// rtl/mhpm_csr.sv - mcycle/minstret/mhpmcounter bank with event selectors and mcountinhibit (option MHPM_OVF_IRQ_EN)
module mhpm_csr
  import mhpm_csr_pkg::*;
#(
  parameter int NUM_HPM    = 4,
  parameter int CNT_WIDTH  = 64,
  parameter int NUM_EVENTS = 8,
  parameter int EVT_SEL_W  = 4
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rstn,
  input  logic [11:0]           csr_addr,
  input  logic                  valid_mcsr_rd,
  input  logic                  valid_mcsr_wr,
  input  logic                  mcsr_set,
  input  logic                  mcsr_clr,
  input  logic [31:0]           write_data,
  output logic [31:0]           read_data,
  output logic                  hpm_hit,
  input  logic                  instr_retire,
  input  logic [NUM_EVENTS-1:0] hpm_event,
  output logic                  hpm_ovf_irq
);

  // Counter slots are indexed by CSR number; slot 1 (mtime) is an empty gap
  localparam int NUM_CNT = 3 + NUM_HPM;
  localparam logic [31:0] INH_MASK = (NUM_CNT >= 32) ? (32'hFFFF_FFFF & ~32'h2)
                                                     : (((32'd1 << NUM_CNT) - 32'd1) & ~32'h2);

  logic [CNT_WIDTH-1:0] cnt    [NUM_CNT];
  logic [31:0]          cnt_hi [NUM_CNT];
  logic [EVT_SEL_W-1:0] evt_sel[NUM_CNT];
  logic [NUM_CNT-1:0]   inc, wr_lo, wr_hi, wr_evt, wrap, of;
  logic [31:0]          inhibit, rd_mux, wval;
  logic                 hit, wr_inh;
  logic                 in_lo, in_hi, in_evt;
  logic [4:0]           idx;
  logic                 unused_bits;

  assign idx    = csr_addr[4:0];
  assign in_lo  = (csr_addr[11:5] == MCYCLE_ADDR[11:5]);
  assign in_hi  = (csr_addr[11:5] == MCYCLEH_ADDR[11:5]);
  assign in_evt = (csr_addr[11:5] == MCOUNTINHIBIT_ADDR[11:5]);

  // Address decode, read mux and per-register write strobes
  always_comb begin
    rd_mux = '0;
    hit    = 1'b0;
    wr_lo  = '0;
    wr_hi  = '0;
    wr_evt = '0;
    wr_inh = 1'b0;
    for (int k = 0; k < NUM_CNT; k++) begin
      if (k != 1 && idx == 5'(k)) begin
        if (in_lo) begin
          hit      = 1'b1;
          rd_mux   = cnt[k][31:0];
          wr_lo[k] = valid_mcsr_wr;
        end
        if (in_hi) begin
          hit      = 1'b1;
          rd_mux   = cnt_hi[k];
          wr_hi[k] = valid_mcsr_wr;
        end
      end
      if (k >= 3 && in_evt && idx == 5'(k)) begin
        hit        = 1'b1;
        rd_mux     = 32'(evt_sel[k]);
        rd_mux[31] = of[k];
        wr_evt[k]  = valid_mcsr_wr;
      end
    end
    if (in_evt && idx == 5'd0) begin
      hit    = 1'b1;
      rd_mux = inhibit;
      wr_inh = valid_mcsr_wr;
    end
  end

  assign wval      = csr_wr_value(rd_mux, write_data, mcsr_set, mcsr_clr);
  assign read_data = (valid_mcsr_rd && hit) ? rd_mux : 32'd0;
  assign hpm_hit   = hit;

  // Increment enables from inhibit state, retire strobe and selected event lines
  always_comb begin
    inc    = '0;
    inc[0] = ~inhibit[0];
    inc[2] = instr_retire & ~inhibit[2];
    for (int k = 3; k < NUM_CNT; k++) begin
      for (int e = 0; e < NUM_EVENTS; e++) begin
        if (evt_sel[k] == EVT_SEL_W'(e + 1) && hpm_event[e] && !inhibit[k])
          inc[k] = 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NUM_CNT; k++) begin : g_cnt
    if (k == 1) begin : g_gap
      assign cnt[k]  = '0;
      assign wrap[k] = 1'b0;
    end else begin : g_ctr
      hpm_counter #(.CNT_WIDTH(CNT_WIDTH)) u_ctr (
        .cpu_clk  (cpu_clk),
        .cpu_rstn (cpu_rstn),
        .inc      (inc[k]),
        .wr_lo    (wr_lo[k]),
        .wr_hi    (wr_hi[k]),
        .wr_value (wval),
        .value    (cnt[k]),
        .wrap     (wrap[k])
      );
    end
    assign cnt_hi[k] = 32'(cnt[k] >> 32);
  end

  // Inhibit and event-selector registers; non-implemented bits never store
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      inhibit <= '0;
      for (int k = 0; k < NUM_CNT; k++)
        evt_sel[k] <= '0;
    end else begin
      if (wr_inh)
        inhibit <= wval & INH_MASK;
      for (int k = 3; k < NUM_CNT; k++) begin
        if (wr_evt[k])
          evt_sel[k] <= wval[EVT_SEL_W-1:0];
      end
    end
  end

`ifdef MHPM_OVF_IRQ_EN
  // Sticky overflow flags (a wrap beats a same-cycle software clear) and registered irq
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      of          <= '0;
      hpm_ovf_irq <= 1'b0;
    end else begin
      hpm_ovf_irq <= |of;
      for (int k = 3; k < NUM_CNT; k++) begin
        if (wrap[k])
          of[k] <= 1'b1;
        else if (wr_evt[k])
          of[k] <= wval[31];
      end
    end
  end
`else
  assign of          = '0;
  assign hpm_ovf_irq = 1'b0;
`endif

  assign unused_bits = ^{wrap, inc[1], wr_lo[1], wr_hi[1], wr_evt[2:0], of[2:0]};

endmodule

// File: tb/tb_mhpm_csr.sv
// tb/tb_mhpm_csr.sv - directed and randomized checks of mhpm_csr against a behavioural model
module tb_mhpm_csr;

  localparam int NUM_HPM    = 4;
  localparam int CNT_WIDTH  = 64;
  localparam int NUM_EVENTS = 8;
  localparam int EVT_SEL_W  = 4;
  localparam int NC         = 3 + NUM_HPM;
  localparam longint unsigned CMASK = (CNT_WIDTH == 64) ? 64'hFFFF_FFFF_FFFF_FFFF
                                                        : ((64'd1 << CNT_WIDTH) - 64'd1);

  logic                  cpu_clk = 1'b0;
  logic                  cpu_rstn;
  logic [11:0]           csr_addr;
  logic                  valid_mcsr_rd, valid_mcsr_wr, mcsr_set, mcsr_clr;
  logic [31:0]           write_data;
  logic [31:0]           read_data;
  logic                  hpm_hit;
  logic                  instr_retire;
  logic [NUM_EVENTS-1:0] hpm_event;
  logic                  hpm_ovf_irq;

  mhpm_csr #(
    .NUM_HPM(NUM_HPM), .CNT_WIDTH(CNT_WIDTH), .NUM_EVENTS(NUM_EVENTS), .EVT_SEL_W(EVT_SEL_W)
  ) dut (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .csr_addr(csr_addr),
    .valid_mcsr_rd(valid_mcsr_rd), .valid_mcsr_wr(valid_mcsr_wr),
    .mcsr_set(mcsr_set), .mcsr_clr(mcsr_clr), .write_data(write_data),
    .read_data(read_data), .hpm_hit(hpm_hit), .instr_retire(instr_retire),
    .hpm_event(hpm_event), .hpm_ovf_irq(hpm_ovf_irq)
  );

  always #50 cpu_clk = ~cpu_clk;

  int n_cmp = 0;
  int n_err = 0;

  longint unsigned m_cnt[NC];
  logic [31:0]     m_inh;
  int unsigned     m_sel[NC];
  bit              m_of[NC];
  bit              m_irq;

  task automatic model_reset();
    for (int k = 0; k < NC; k++) begin
      m_cnt[k] = 0; m_sel[k] = 0; m_of[k] = 0;
    end
    m_inh = 0; m_irq = 0;
  endtask

  // Architectural view of a CSR read from the model state
  function automatic void mread(input logic [11:0] a, output logic [31:0] v, output bit h);
    longint unsigned c;
    v = 0; h = 0;
    for (int k = 0; k < NC; k++) begin
      c = m_cnt[k];
      if (k != 1 && a == 12'hB00 + 12'(k)) begin h = 1; v = c[31:0]; end
      if (k != 1 && a == 12'hB80 + 12'(k)) begin h = 1; v = 32'(c >> 32); end
      if (k >= 3 && a == 12'h320 + 12'(k)) begin
        h = 1; v = m_sel[k] | (m_of[k] ? 32'h8000_0000 : 32'h0);
      end
    end
    if (a == 12'h320) begin h = 1; v = m_inh; end
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one clock: model next state from the inputs now driven, then commit at the edge
  task automatic step();
    longint unsigned n_cnt[NC];
    logic [31:0]     n_inh, old, nv, imask;
    int unsigned     n_sel[NC];
    bit              n_of[NC];
    bit              n_irq, h, en, wrapped;
    n_inh = m_inh; n_irq = 0; old = 0; nv = 0;
    for (int k = 0; k < NC; k++) begin
      n_cnt[k] = m_cnt[k]; n_sel[k] = m_sel[k]; n_of[k] = m_of[k];
`ifdef MHPM_OVF_IRQ_EN
      n_irq = n_irq | m_of[k];
`endif
    end
    if (valid_mcsr_wr) begin
      mread(csr_addr, old, h);
      nv = mcsr_set ? (old | write_data) : mcsr_clr ? (old & ~write_data) : write_data;
    end
    for (int k = 0; k < NC; k++) begin
      if (k == 1) continue;
      en = 0; wrapped = 0;
      if (k == 0) en = !m_inh[0];
      else if (k == 2) en = instr_retire && !m_inh[2];
      else if (m_sel[k] >= 1 && m_sel[k] <= NUM_EVENTS) en = !m_inh[k] && hpm_event[m_sel[k] - 1];
      if (valid_mcsr_wr && csr_addr == 12'hB00 + 12'(k))
        n_cnt[k] = (m_cnt[k] & 64'hFFFF_FFFF_0000_0000) | longint'(nv);
      else if (valid_mcsr_wr && csr_addr == 12'hB80 + 12'(k))
        n_cnt[k] = ((m_cnt[k] & 64'hFFFF_FFFF) | (longint'(nv) << 32)) & CMASK;
      else if (en) begin
        wrapped  = (m_cnt[k] == CMASK);
        n_cnt[k] = (m_cnt[k] + 1) & CMASK;
      end
      if (k >= 3 && valid_mcsr_wr && csr_addr == 12'h320 + 12'(k)) begin
        n_sel[k] = nv % (1 << EVT_SEL_W);
`ifdef MHPM_OVF_IRQ_EN
        n_of[k] = nv[31];
`endif
      end
`ifdef MHPM_OVF_IRQ_EN
      if (wrapped) n_of[k] = 1;
`endif
    end
    if (valid_mcsr_wr && csr_addr == 12'h320) begin
      imask = 0;
      for (int k = 0; k < NC; k++) if (k != 1) imask[k] = 1'b1;
      n_inh = nv & imask;
    end
    @(posedge cpu_clk);
    for (int k = 0; k < NC; k++) begin
      m_cnt[k] = n_cnt[k]; m_sel[k] = n_sel[k]; m_of[k] = n_of[k];
    end
    m_inh = n_inh; m_irq = n_irq;
    @(negedge cpu_clk);
  endtask

  task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic s, input logic c);
    csr_addr = a; write_data = d; valid_mcsr_wr = 1; mcsr_set = s; mcsr_clr = c;
    step();
    valid_mcsr_wr = 0; mcsr_set = 0; mcsr_clr = 0;
  endtask

  task automatic rd_const(input string tag, input logic [11:0] a, input logic [31:0] exp);
    csr_addr = a; valid_mcsr_rd = 1;
    #1;
    check(tag, read_data, exp);
    valid_mcsr_rd = 0;
  endtask

  task automatic rd_model(input string tag, input logic [11:0] a);
    logic [31:0] v;
    bit h;
    csr_addr = a; valid_mcsr_rd = 1;
    #1;
    mread(a, v, h);
    check(tag, read_data, v);
    check({tag, "_hit"}, 32'(hpm_hit), 32'(h));
    valid_mcsr_rd = 0;
  endtask

  logic [11:0] addr_pool[$];
  longint unsigned b_cyc, b_ret;

  initial begin
    cpu_rstn = 0; csr_addr = 0; valid_mcsr_rd = 0; valid_mcsr_wr = 0;
    mcsr_set = 0; mcsr_clr = 0; write_data = 0; instr_retire = 0; hpm_event = 0;
    model_reset();
    #1;
    rd_const("rst_mcycle", 12'hB00, 32'h0);
    rd_const("rst_inhibit", 12'h320, 32'h0);
    check("rst_irq", 32'(hpm_ovf_irq), 32'h0);
    @(negedge cpu_clk);
    cpu_rstn = 1;

    // free-running mcycle
    repeat (10) step();
    rd_const("t1_mcycle", 12'hB00, 32'd10);
    rd_const("t1_mcycleh", 12'hB80, 32'd0);
    rd_const("t1_minstret", 12'hB02, 32'd0);

    // carry into high half, then full wrap
    do_write(12'hB00, 32'hFFFF_FFFF, 0, 0);
    step();
    rd_const("t2_lo_carry", 12'hB00, 32'h0);
    rd_const("t2_hi_carry", 12'hB80, 32'h1);
    do_write(12'hB00, 32'hFFFF_FFFF, 0, 0);
    do_write(12'hB80, 32'hFFFF_FFFF, 0, 0);
    rd_const("t2_hi_written", 12'hB80, 32'hFFFF_FFFF);
    rd_const("t2_lo_kept", 12'hB00, 32'hFFFF_FFFF);
    step();
    rd_const("t2_lo_wrap", 12'hB00, 32'h0);
    rd_const("t2_hi_wrap", 12'hB80, 32'h0);

    // event selection
    do_write(12'h323, 32'd2, 0, 0);
    hpm_event = 8'h02; repeat (5) step();
    hpm_event = 8'h01; repeat (3) step();
    hpm_event = 8'h00;
    rd_const("t3_hpm3", 12'hB03, 32'd5);
    do_write(12'h324, 32'd9, 0, 0);
    hpm_event = 8'hFF; repeat (4) step();
    hpm_event = 8'h00;
    rd_const("t3_sel9", 12'hB04, 32'd0);
    rd_const("t3_sel9_rd", 12'h324, 32'd9);

    // inhibit via CSRRS / CSRRC
    instr_retire = 1;
    b_cyc = m_cnt[0]; b_ret = m_cnt[2];
    do_write(12'h320, 32'h5, 1, 0);
    repeat (20) step();
    rd_const("t4_cyc_frozen", 12'hB00, 32'(b_cyc + 1));
    rd_const("t4_ret_frozen", 12'hB02, 32'(b_ret + 1));
    rd_const("t4_inh_rd", 12'h320, 32'h5);
    do_write(12'h320, 32'h5, 0, 1);
    repeat (3) step();
    instr_retire = 0;
    rd_const("t4_cyc_resume", 12'hB00, 32'(b_cyc + 4));
    rd_const("t4_ret_resume", 12'hB02, 32'(b_ret + 4));

    // write/increment collision and out-of-range addresses
    hpm_event = 8'h02;
    do_write(12'hB03, 32'h1234, 0, 0);
    hpm_event = 8'h00;
    rd_const("t5_collide", 12'hB03, 32'h1234);
    rd_const("t5_b1f", 12'hB1F, 32'h0);
    check("t5_b1f_hit", 32'(hpm_hit), 32'h0);
    rd_const("t5_b07", 12'hB07, 32'h0);
    check("t5_b07_hit", 32'(hpm_hit), 32'h0);

    // counter wrap by increment and the overflow flag
    do_write(12'hB83, 32'hFFFF_FFFF, 0, 0);
    do_write(12'hB03, 32'hFFFF_FFFF, 0, 0);
    hpm_event = 8'h02; step(); hpm_event = 8'h00;
    rd_const("t6_wrap_lo", 12'hB03, 32'h0);
    rd_const("t6_wrap_hi", 12'hB83, 32'h0);
`ifdef MHPM_OVF_IRQ_EN
    rd_const("t6_of_set", 12'h323, 32'h8000_0002);
    check("t6_irq_early", 32'(hpm_ovf_irq), 32'h0);
    step();
    check("t6_irq_on", 32'(hpm_ovf_irq), 32'h1);
    do_write(12'h323, 32'h8000_0000, 0, 1);
    check("t6_irq_hold", 32'(hpm_ovf_irq), 32'h1);
    rd_const("t6_of_clr", 12'h323, 32'h2);
    step();
    check("t6_irq_off", 32'(hpm_ovf_irq), 32'h0);
`else
    rd_const("t6_no_of", 12'h323, 32'h2);
    do_write(12'h323, 32'h8000_0002, 0, 0);
    rd_const("t6_of_ignored", 12'h323, 32'h2);
    step();
    check("t6_irq_tied", 32'(hpm_ovf_irq), 32'h0);
`endif

    // randomized traffic against the model
    for (int k = 0; k < NC; k++) begin
      if (k != 1) begin
        addr_pool.push_back(12'hB00 + 12'(k));
        addr_pool.push_back(12'hB80 + 12'(k));
      end
      if (k >= 3) addr_pool.push_back(12'h320 + 12'(k));
    end
    addr_pool.push_back(12'h320);
    addr_pool.push_back(12'hB01);
    addr_pool.push_back(12'hB1F);
    addr_pool.push_back(12'h321);
    addr_pool.push_back(12'h3A0);
    addr_pool.push_back(12'h7C0);
    for (int i = 0; i < 400; i++) begin
      logic [31:0] v;
      bit h;
      csr_addr      = addr_pool[$urandom_range(0, addr_pool.size() - 1)];
      valid_mcsr_wr = ($urandom_range(0, 9) < 3);
      valid_mcsr_rd = $urandom_range(0, 1);
      mcsr_set      = valid_mcsr_wr && ($urandom_range(0, 2) == 0);
      mcsr_clr      = valid_mcsr_wr && !mcsr_set && ($urandom_range(0, 1) == 0);
      write_data    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      instr_retire  = $urandom_range(0, 1);
      hpm_event     = NUM_EVENTS'($urandom);
      #1;
      mread(csr_addr, v, h);
      check("rnd_rdata", read_data, valid_mcsr_rd ? v : 32'h0);
      check("rnd_hit", 32'(hpm_hit), 32'(h));
      check("rnd_irq", 32'(hpm_ovf_irq), 32'(m_irq));
      step();
    end
    valid_mcsr_wr = 0; valid_mcsr_rd = 0; mcsr_set = 0; mcsr_clr = 0;
    instr_retire = 0; hpm_event = 0;
    foreach (addr_pool[i]) rd_model("sweep", addr_pool[i]);

    // asynchronous reset in the middle of counting
    do_write(12'h320, 32'h0, 0, 0);
    repeat (3) step();
    cpu_rstn = 0;
    #1;
    model_reset();
    rd_const("arst_mcycle", 12'hB00, 32'h0);
    rd_const("arst_hpm3", 12'h323, 32'h0);
    check("arst_irq", 32'(hpm_ovf_irq), 32'h0);
    cpu_rstn = 1;
    repeat (5) step();
    rd_const("post_rst_mcycle", 12'hB00, 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
